// File: rtl/bp_resolve_queue.sv
// In-order resolve queue: one predictor packet per in-flight branch, looked up by
// tag at execute to drive a registered predictor update; squashes younger entries on mispredict.
`ifndef N
`define N 2
`endif

package bp_resolve_queue_pkg;
  typedef struct packed {
    logic [7:0] BHR_state;
    logic [9:0] gshare_PHT_idx;
    logic       pred_taken;
  } BRANCH_PREDICTOR_PACKET;
endpackage

module bp_resolve_queue
  import bp_resolve_queue_pkg::*;
#(
  parameter int N     = `N,
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N-1:0]                   alloc_valid,
  input  BRANCH_PREDICTOR_PACKET [N-1:0] alloc_packets,
  output logic                           alloc_ready,
  output logic [N-1:0][TAG_W-1:0]        alloc_tags,
  input  logic                           resolve_valid,
  input  logic [TAG_W-1:0]               resolve_tag,
  input  logic                           resolve_taken,
  input  logic                           resolve_mispred,
  input  logic                           flush,
  output BRANCH_PREDICTOR_PACKET         bs_bp_packet,
  output logic                           resolving_valid_branch,
  output logic                           actual_taken,
  output logic                           mispred,
  output logic [TAG_W:0]                 count,
  output logic                           empty,
  output logic                           full
);

  logic [TAG_W:0]         head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]       valid_q, valid_d, resolved_q, resolved_d;
  BRANCH_PREDICTOR_PACKET pkt_q [DEPTH];
  BRANCH_PREDICTOR_PACKET pkt_d [DEPTH];

  logic [TAG_W-1:0] head_idx, tail_idx, off_tag, ent_idx, alloc_cnt;
  logic [TAG_W:0]   free_cnt, retire_n;
  logic             retire_stop, res_hit, squash;

  assign head_idx    = head_q[TAG_W-1:0];
  assign tail_idx    = tail_q[TAG_W-1:0];
  assign count       = tail_q - head_q;
  assign empty       = (count == '0);
  assign full        = (count == (TAG_W+1)'(DEPTH));
  assign free_cnt    = (TAG_W+1)'(DEPTH) - count;
  assign alloc_ready = (free_cnt >= (TAG_W+1)'(N));

  // A resolve only counts once: repeat resolves of a resolved entry are ignored.
  assign res_hit = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];
  assign squash  = res_hit && resolve_mispred;
  assign off_tag = resolve_tag - head_idx;

  always_comb begin
    alloc_cnt  = '0;
    alloc_tags = '0;
    for (int l = 0; l < N; l++) begin
      if (alloc_valid[l]) begin
        alloc_tags[l] = tail_idx + alloc_cnt;
        alloc_cnt     = alloc_cnt + TAG_W'(1);
      end
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    pkt_d       = pkt_q;
    retire_n    = '0;
    retire_stop = 1'b0;
    ent_idx     = '0;

    // Retire looks only at registered resolved bits, so a same-cycle resolve waits a cycle.
    for (int i = 0; i < N; i++) begin
      ent_idx = head_idx + TAG_W'(i);
      if (!retire_stop && valid_q[ent_idx] && resolved_q[ent_idx]) begin
        valid_d[ent_idx]    = 1'b0;
        resolved_d[ent_idx] = 1'b0;
        retire_n            = retire_n + (TAG_W+1)'(1);
      end else begin
        retire_stop = 1'b1;
      end
    end
    head_d = head_q + retire_n;

    if (res_hit) resolved_d[resolve_tag] = 1'b1;

    if (squash) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (TAG_W'(e) - head_idx > off_tag) begin
          valid_d[e]    = 1'b0;
          resolved_d[e] = 1'b0;
        end
      end
      tail_d = head_q + (TAG_W+1)'(off_tag) + (TAG_W+1)'(1);
    end else if (alloc_ready) begin
      for (int l = 0; l < N; l++) begin
        if (alloc_valid[l]) begin
          valid_d[alloc_tags[l]]    = 1'b1;
          resolved_d[alloc_tags[l]] = 1'b0;
          pkt_d[alloc_tags[l]]      = alloc_packets[l];
        end
      end
      tail_d = tail_q + (TAG_W+1)'(alloc_cnt);
    end

    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      valid_d    = '0;
      resolved_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
    end
  end

  always_ff @(posedge clock) begin
    pkt_q <= pkt_d;
  end

  // Predictor update stage: one-cycle registered view of the resolve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bs_bp_packet           <= '0;
      resolving_valid_branch <= 1'b0;
      actual_taken           <= 1'b0;
      mispred                <= 1'b0;
    end else begin
      resolving_valid_branch <= res_hit && !flush;
      if (res_hit && !flush) begin
        bs_bp_packet <= pkt_q[resolve_tag];
        actual_taken <= resolve_taken;
        mispred      <= resolve_mispred;
      end
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue (N=2, DEPTH=8) with hand-computed expectations.
module tb_bp_resolve_queue;
  import bp_resolve_queue_pkg::*;

  logic                           clock = 1'b0;
  logic                           reset;
  logic [1:0]                     alloc_valid;
  BRANCH_PREDICTOR_PACKET [1:0]   alloc_packets;
  logic                           alloc_ready;
  logic [1:0][2:0]                alloc_tags;
  logic                           resolve_valid;
  logic [2:0]                     resolve_tag;
  logic                           resolve_taken;
  logic                           resolve_mispred;
  logic                           flush;
  BRANCH_PREDICTOR_PACKET         bs_bp_packet;
  logic                           resolving_valid_branch;
  logic                           actual_taken;
  logic                           mispred;
  logic [3:0]                     count;
  logic                           empty;
  logic                           full;

  int n_cmp = 0;
  int n_err = 0;

  bp_resolve_queue #(.N(2), .DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_packets(alloc_packets),
    .alloc_ready(alloc_ready), .alloc_tags(alloc_tags),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_taken(resolve_taken), .resolve_mispred(resolve_mispred),
    .flush(flush), .bs_bp_packet(bs_bp_packet),
    .resolving_valid_branch(resolving_valid_branch),
    .actual_taken(actual_taken), .mispred(mispred),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  function automatic BRANCH_PREDICTOR_PACKET mk(input int bhr, input int idx, input bit pt);
    BRANCH_PREDICTOR_PACKET p;
    p.BHR_state      = 8'(bhr);
    p.gshare_PHT_idx = 10'(idx);
    p.pred_taken     = pt;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_valid     = 2'b00;
    alloc_packets   = '0;
    resolve_valid   = 1'b0;
    resolve_tag     = 3'd0;
    resolve_taken   = 1'b0;
    resolve_mispred = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic alloc2(input BRANCH_PREDICTOR_PACKET p0, input BRANCH_PREDICTOR_PACKET p1);
    alloc_valid      = 2'b11;
    alloc_packets[0] = p0;
    alloc_packets[1] = p1;
    tick();
    alloc_valid = 2'b00;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || alloc_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_flags: empty=%b full=%b ready=%b expected 1 0 1", empty, full, alloc_ready);
    end
    n_cmp++;
    if (resolving_valid_branch !== 1'b0 || bs_bp_packet !== '0 || actual_taken !== 1'b0 || mispred !== 1'b0) begin
      n_err++; $display("FAIL rst_outputs: rvb=%b pkt=%h taken=%b mis=%b expected all 0",
                        resolving_valid_branch, bs_bp_packet, actual_taken, mispred);
    end
  endtask

  task automatic test_reset_mid_traffic();
    alloc2(mk(1, 1, 0), mk(2, 2, 0));
    alloc2(mk(3, 3, 0), mk(4, 4, 0));
    alloc_valid = 2'b01; alloc_packets[0] = mk(5, 5, 1);
    tick();
    alloc_valid = 2'b00;
    n_cmp++;
    if (count !== 4'd5) begin n_err++; $display("FAIL midrst_count5: got %0d expected 5", count); end
    resolve_valid = 1'b1; resolve_tag = 3'd0; resolve_taken = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (resolving_valid_branch !== 1'b1) begin
      n_err++; $display("FAIL midrst_pulse: got %b expected 1", resolving_valid_branch);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (resolving_valid_branch !== 1'b0 || bs_bp_packet !== '0 || actual_taken !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs: rvb=%b pkt=%h taken=%b expected 0 0 0",
                        resolving_valid_branch, bs_bp_packet, actual_taken);
    end
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1 || alloc_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_state: count=%0d empty=%b ready=%b expected 0 1 1", count, empty, alloc_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alloc_compaction();
    alloc_valid = 2'b10; alloc_packets[1] = mk(10, 10, 0);
    #1;
    n_cmp++;
    if (alloc_tags[1] !== 3'd0) begin n_err++; $display("FAIL compact_lane1: got %0d expected 0", alloc_tags[1]); end
    tick();
    alloc_valid = 2'b11; alloc_packets[0] = mk(11, 11, 0); alloc_packets[1] = mk(12, 12, 0);
    #1;
    n_cmp++;
    if (alloc_tags[0] !== 3'd1 || alloc_tags[1] !== 3'd2) begin
      n_err++; $display("FAIL compact_tags: got %0d,%0d expected 1,2", alloc_tags[0], alloc_tags[1]);
    end
    tick();
    alloc_valid = 2'b00;
    n_cmp++;
    if (count !== 4'd3) begin n_err++; $display("FAIL compact_count: got %0d expected 3", count); end
    do_flush();
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL flush_clear: count=%0d empty=%b expected 0 1", count, empty);
    end
  endtask

  task automatic test_resolve_readback();
    alloc2(mk(20, 20, 0), mk(21, 21, 0));
    alloc2(mk(22, 22, 1), mk(5, 9, 0));
    resolve_valid = 1'b1; resolve_tag = 3'd3; resolve_taken = 1'b1; resolve_mispred = 1'b0;
    tick();
    resolve_valid = 1'b0;
    n_cmp++;
    if (resolving_valid_branch !== 1'b1) begin n_err++; $display("FAIL rb_pulse: got %b expected 1", resolving_valid_branch); end
    n_cmp++;
    if (bs_bp_packet !== mk(5, 9, 0)) begin n_err++; $display("FAIL rb_packet: got %h expected %h", bs_bp_packet, mk(5, 9, 0)); end
    n_cmp++;
    if (actual_taken !== 1'b1 || mispred !== 1'b0) begin
      n_err++; $display("FAIL rb_dir: taken=%b mis=%b expected 1 0", actual_taken, mispred);
    end
    tick();
    n_cmp++;
    if (resolving_valid_branch !== 1'b0) begin n_err++; $display("FAIL rb_single: got %b expected 0", resolving_valid_branch); end
    resolve_valid = 1'b1; resolve_tag = 3'd3;
    tick();
    resolve_valid = 1'b0;
    n_cmp++;
    if (resolving_valid_branch !== 1'b0) begin n_err++; $display("FAIL rb_repeat: got %b expected 0", resolving_valid_branch); end
    n_cmp++;
    if (count !== 4'd4) begin n_err++; $display("FAIL rb_count: got %0d expected 4", count); end
    do_flush();
  endtask

  task automatic test_mispred_squash();
    alloc2(mk(30, 30, 0), mk(31, 31, 0));
    alloc2(mk(32, 32, 0), mk(33, 33, 0));
    alloc2(mk(34, 34, 0), mk(35, 35, 0));
    n_cmp++;
    if (count !== 4'd6) begin n_err++; $display("FAIL sq_fill: got %0d expected 6", count); end
    resolve_valid = 1'b1; resolve_tag = 3'd2; resolve_taken = 1'b0; resolve_mispred = 1'b1;
    alloc_valid = 2'b11; alloc_packets[0] = mk(36, 36, 0); alloc_packets[1] = mk(37, 37, 0);
    tick();
    idle();
    n_cmp++;
    if (count !== 4'd3) begin n_err++; $display("FAIL sq_count: got %0d expected 3", count); end
    n_cmp++;
    if (resolving_valid_branch !== 1'b1 || mispred !== 1'b1 || bs_bp_packet !== mk(32, 32, 0)) begin
      n_err++; $display("FAIL sq_update: rvb=%b mis=%b pkt=%h expected 1 1 %h",
                        resolving_valid_branch, mispred, bs_bp_packet, mk(32, 32, 0));
    end
    alloc_valid = 2'b01;
    #1;
    n_cmp++;
    if (alloc_tags[0] !== 3'd3) begin n_err++; $display("FAIL sq_tail: got %0d expected 3", alloc_tags[0]); end
    alloc_valid = 2'b00;
    resolve_valid = 1'b1; resolve_tag = 3'd4;
    tick();
    resolve_valid = 1'b0;
    n_cmp++;
    if (resolving_valid_branch !== 1'b0) begin n_err++; $display("FAIL sq_dead_tag: got %b expected 0", resolving_valid_branch); end
    do_flush();
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) alloc2(mk(40 + 2 * i, i, 0), mk(41 + 2 * i, i, 1));
    n_cmp++;
    if (count !== 4'd8 || full !== 1'b1 || alloc_ready !== 1'b0) begin
      n_err++; $display("FAIL full_flags: count=%0d full=%b ready=%b expected 8 1 0", count, full, alloc_ready);
    end
    alloc2(mk(99, 99, 0), mk(98, 98, 0));
    n_cmp++;
    if (count !== 4'd8) begin n_err++; $display("FAIL full_drop: got %0d expected 8", count); end
    resolve_valid = 1'b1; resolve_tag = 3'd1;
    tick();
    resolve_tag = 3'd0;
    tick();
    resolve_valid = 1'b0;
    n_cmp++;
    if (count !== 4'd8) begin n_err++; $display("FAIL wrap_no_early_retire: got %0d expected 8", count); end
    tick();
    n_cmp++;
    if (count !== 4'd6 || alloc_ready !== 1'b1) begin
      n_err++; $display("FAIL wrap_retire2: count=%0d ready=%b expected 6 1", count, alloc_ready);
    end
    alloc_valid = 2'b11; alloc_packets[0] = mk(50, 50, 0); alloc_packets[1] = mk(51, 51, 0);
    #1;
    n_cmp++;
    if (alloc_tags[0] !== 3'd0 || alloc_tags[1] !== 3'd1) begin
      n_err++; $display("FAIL wrap_tags: got %0d,%0d expected 0,1", alloc_tags[0], alloc_tags[1]);
    end
    tick();
    alloc_valid = 2'b00;
    n_cmp++;
    if (count !== 4'd8 || full !== 1'b1) begin
      n_err++; $display("FAIL wrap_refill: count=%0d full=%b expected 8 1", count, full);
    end
    do_flush();
  endtask

  task automatic test_flush_vs_resolve();
    alloc2(mk(60, 60, 0), mk(61, 61, 0));
    resolve_valid = 1'b1; resolve_tag = 3'd0; resolve_taken = 1'b1; flush = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (resolving_valid_branch !== 1'b0) begin n_err++; $display("FAIL flush_pulse: got %b expected 0", resolving_valid_branch); end
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL flush_count: count=%0d empty=%b expected 0 1", count, empty);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_reset_mid_traffic();
    test_alloc_compaction();
    test_resolve_readback();
    test_mispred_squash();
    test_full_wrap();
    test_flush_vs_resolve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
